io_controlador: RTL



---
 rtl/io_controlador.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/io_controlador.sv
// Confirm-button sequencer for the processor's in/out instructions: arms, debounces a press, latches data, pulses sinal.
// Optional build macro IO_TIMEOUT_EN adds a forced-completion timeout and the sticky erro_timeout flag.
module io_controlador #(
    parameter int WIDTH      = 32,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             botao,
    input  logic [WIDTH-1:0] chaves,
    input  logic [WIDTH-1:0] dado_out,
    output logic             sinal,
    output logic [WIDTH-1:0] dado_in,
    output logic [WIDTH-1:0] display,
    output logic             ocupado,
    output logic             erro_timeout
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {OCIOSO, ARM, ESPERA, FILTRO, CONFIRMA} estado_t;

    estado_t       estado, proximo;
    logic          botao_m, botao_s;
    logic [CW-1:0] contador, contador_prox;
    logic          req;
    logic          estouro;

    assign req = req_in | req_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            botao_m <= 1'b0;
            botao_s <= 1'b0;
        end else begin
            botao_m <= botao;
            botao_s <= botao_m;
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tempo;

    // Counts cycles spent waiting for a press; reaching TIMEOUT forces completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tempo        <= '0;
            erro_timeout <= 1'b0;
        end else begin
            if (ocupado && !estouro)
                tempo <= tempo + 1'b1;
            else
                tempo <= '0;
            if (estouro && req)
                erro_timeout <= 1'b1;
        end
    end

    assign estouro = ocupado && (tempo == TW'(TIMEOUT - 1));
`else
    assign estouro      = 1'b0;
    assign erro_timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            contador <= '0;
        end else begin
            estado   <= proximo;
            contador <= contador_prox;
        end
    end

    // Dropping the request aborts from any waiting state and takes priority over confirmation.
    always_comb begin
        proximo       = estado;
        contador_prox = contador;
        unique case (estado)
            OCIOSO: begin
                contador_prox = '0;
                if (req)
                    proximo = ARM;
            end
            ARM: begin
                if (!req)
                    proximo = OCIOSO;
                else if (estouro)
                    proximo = CONFIRMA;
                else if (!botao_s)
                    proximo = ESPERA;
            end
            ESPERA: begin
                if (!req)
                    proximo = OCIOSO;
                else if (estouro)
                    proximo = CONFIRMA;
                else if (botao_s) begin
                    proximo       = FILTRO;
                    contador_prox = CW'(1);
                end
            end
            FILTRO: begin
                if (!req) begin
                    proximo       = OCIOSO;
                    contador_prox = '0;
                end else if (estouro || contador == CW'(DEB_CYCLES))
                    proximo = CONFIRMA;
                else if (!botao_s) begin
                    proximo       = ESPERA;
                    contador_prox = '0;
                end else
                    contador_prox = contador + 1'b1;
            end
            CONFIRMA: begin
                proximo       = ARM;
                contador_prox = '0;
            end
            default: begin
                proximo       = OCIOSO;
                contador_prox = '0;
            end
        endcase
    end

    always_comb begin
        ocupado = (estado == ARM) || (estado == ESPERA) || (estado == FILTRO);
    end

    // Data is captured on the edge entering CONFIRMA so it is valid alongside sinal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal   <= 1'b0;
            dado_in <= '0;
            display <= '0;
        end else begin
            sinal <= (proximo == CONFIRMA);
            if (proximo == CONFIRMA) begin
                if (req_in)
                    dado_in <= estouro ? '0 : chaves;
                else if (req_out)
                    display <= dado_out;
            end
        end
    end

endmodule
